// File: rtl/uart_pkg.sv
// Shared definitions for the 15-byte UART link, used by both receiver and transmitter.
package uart_pkg;

    localparam int unsigned DEF_OVS      = 8;
    localparam int unsigned DEF_NBYTES   = 15;
    localparam int unsigned DEF_GAP_BITS = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        GAP,
        BREAK
    } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// Single-byte deserialiser: rx synchroniser, start validation, 8 data bits LSB first, stop check.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int unsigned OVS = DEF_OVS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       byte_start_o,
    output logic       byte_valid_o,
    output logic       byte_err_o,
    output logic       line_idle_o
);

    localparam int unsigned PW = $clog2(OVS);
    localparam logic [PW-1:0] PH_MID  = PW'(OVS / 2 - 1);
    localparam logic [PW-1:0] PH_LAST = PW'(OVS - 1);

    logic            sync1_q, rxs_q;
    rx_state_e       state_q, state_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;

    // The synchroniser presets to the idle level so reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
            state_q <= IDLE;
            phase_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            sync1_q <= rx_i;
            rxs_q   <= sync1_q;
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_start_o = 1'b0;
        byte_valid_o = 1'b0;
        byte_err_o   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    phase_d = '0;
                    state_d = START;
                end
            end
            START: begin
                if (phase_q == PH_MID) begin
                    if (rxs_q) begin
                        state_d = IDLE;
                    end else begin
                        phase_d      = '0;
                        bit_d        = '0;
                        byte_start_o = 1'b1;
                        state_d      = DATA;
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            DATA: begin
                if (phase_q == PH_LAST) begin
                    phase_d         = '0;
                    shift_d[bit_q]  = rxs_q;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            STOP: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    if (rxs_q) begin
                        byte_valid_o = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        byte_err_o = 1'b1;
                        state_d    = BREAK;
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            // After a bad stop the line must sit high for a whole bit before we rearm.
            BREAK: begin
                if (!rxs_q) begin
                    phase_d = '0;
                end else if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    state_d = IDLE;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data_o      = shift_q;
    assign line_idle_o = (state_q == IDLE);

endmodule

// File: rtl/uart_rx_15bytes.sv
// Frame-level receiver: numbers bytes 0..NBYTES-1, times inter-byte gaps, and raises we/RXDone/frameErr.
module uart_rx_15bytes
    import uart_pkg::*;
#(
    parameter int unsigned OVS      = DEF_OVS,
    parameter int unsigned NBYTES   = DEF_NBYTES,
    parameter int unsigned GAP_BITS = DEF_GAP_BITS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic [3:0] addr,
    output logic       we,
    output logic       RXDone,
    output logic       frameErr,
    output logic       busy
);

    localparam int unsigned GAP_LIMIT = GAP_BITS * OVS;
    localparam int unsigned GW        = $clog2(GAP_LIMIT + 1);
    localparam logic [GW-1:0] GAP_END   = GW'(GAP_LIMIT - 1);
    localparam logic [3:0]    LAST_BYTE = 4'(NBYTES - 1);

    logic [7:0]    rx_byte;
    logic          byte_start, byte_valid, byte_err, line_idle;

    logic [7:0]    data_q, data_d;
    logic [3:0]    addr_q, addr_d;
    logic [3:0]    byte_cnt_q, byte_cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          we_q, we_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;

    uart_rx_byte #(
        .OVS(OVS)
    ) u_byte (
        .clk          (clk),
        .reset        (reset),
        .rx_i         (rx),
        .data_o       (rx_byte),
        .byte_start_o (byte_start),
        .byte_valid_o (byte_valid),
        .byte_err_o   (byte_err),
        .line_idle_o  (line_idle)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q     <= '0;
            addr_q     <= '0;
            byte_cnt_q <= '0;
            gap_q      <= '0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            data_q     <= data_d;
            addr_q     <= addr_d;
            byte_cnt_q <= byte_cnt_d;
            gap_q      <= gap_d;
            we_q       <= we_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    // The gap timer only runs while a frame is open and the byte engine waits for a start edge.
    always_comb begin
        data_d     = data_q;
        addr_d     = addr_q;
        byte_cnt_d = byte_cnt_q;
        gap_d      = '0;
        we_d       = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        busy_d     = busy_q;
        if (byte_start) begin
            busy_d = 1'b1;
        end
        if (byte_valid) begin
            data_d = rx_byte;
            addr_d = byte_cnt_q;
            we_d   = 1'b1;
            if (byte_cnt_q == LAST_BYTE) begin
                done_d     = 1'b1;
                byte_cnt_d = '0;
                busy_d     = 1'b0;
            end else begin
                byte_cnt_d = byte_cnt_q + 4'd1;
            end
        end else if (byte_err) begin
            err_d      = 1'b1;
            byte_cnt_d = '0;
            busy_d     = 1'b0;
        end else if (busy_q && line_idle) begin
            if (gap_q == GAP_END) begin
                err_d      = 1'b1;
                byte_cnt_d = '0;
                busy_d     = 1'b0;
            end else begin
                gap_d = gap_q + GW'(1);
            end
        end
    end

    assign data     = data_q;
    assign addr     = addr_q;
    assign we       = we_q;
    assign RXDone   = done_q;
    assign frameErr = err_q;
    assign busy     = busy_q;

endmodule
